// File: rtl/lbist_pkg.sv
// ----------------------------------------------------------------------------
// lbist_pkg : shared LBIST state encoding and width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lbist_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_COMPARE = 3'd5,
      ST_DONE    = 3'd6
   } lbist_state_e;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lbist_cnt.sv
// ----------------------------------------------------------------------------
// lbist_cnt : terminal-count counter with synchronous clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lbist_cnt #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 15,
   parameter bit WRAP    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Non-wrapping counters step past MAX_VAL once, so the final value is visible.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (WRAP && (cnt_q == c_max)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == c_max);

endmodule

`default_nettype wire

// File: rtl/lbist_ctrl.sv
// ----------------------------------------------------------------------------
// lbist_ctrl : logic-BIST run sequencer (shift/capture/unload/compare)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lbist_ctrl
   import lbist_pkg::*;
#(
   parameter int                CHAIN_LEN  = 64,
   parameter int                N_PATTERNS = 1000,
   parameter int                SIG_W      = 20,
   parameter logic [SIG_W-1:0]  GOLDEN_SIG = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SIG_W-1:0] misr_sig,
   output logic             test_mode,
   output logic             lfsr_rst_n,
   output logic             lfsr_en,
   output logic             misr_clr,
   output logic             misr_en,
   output logic             scan_en,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   localparam int SHIFT_W = cnt_w(CHAIN_LEN);
   localparam int PAT_W   = cnt_w(N_PATTERNS + 1);

   lbist_state_e state_q, state_d;

   logic test_mode_q, lfsr_rst_n_q, lfsr_en_q, misr_clr_q, misr_en_q;
   logic scan_en_q, busy_q, done_q, pass_q;
   logic test_mode_d, lfsr_rst_n_d, lfsr_en_d, misr_clr_d, misr_en_d;
   logic scan_en_d, busy_d, done_d, pass_d;

   logic [SHIFT_W-1:0] shift_cnt_unused;
   logic [PAT_W-1:0]   pat_cnt;
   logic               shift_tc;
   logic               pat_tc;
   logic               shift_run;

   assign shift_run = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);

   lbist_cnt #(
      .WIDTH   (SHIFT_W),
      .MAX_VAL (CHAIN_LEN - 1),
      .WRAP    (1'b1)
   ) u_shift_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (shift_run),
      .clr_i (state_q == ST_INIT),
      .cnt_o (shift_cnt_unused),
      .tc_o  (shift_tc)
   );

   // tc marks the last pattern; the count still steps on to N_PATTERNS.
   lbist_cnt #(
      .WIDTH   (PAT_W),
      .MAX_VAL (N_PATTERNS - 1),
      .WRAP    (1'b0)
   ) u_pat_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (state_q == ST_CAPTURE),
      .clr_i (state_q == ST_INIT),
      .cnt_o (pat_cnt),
      .tc_o  (pat_tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_INIT;
         ST_INIT:    state_d = ST_SHIFT;
         ST_SHIFT:   if (shift_tc) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = pat_tc ? ST_UNLOAD : ST_SHIFT;
         ST_UNLOAD:  if (shift_tc) state_d = ST_COMPARE;
         ST_COMPARE: state_d = ST_DONE;
         ST_DONE:    if (start) state_d = ST_INIT;
         default:    state_d = ST_IDLE;
      endcase

      busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
      test_mode_d  = busy_d;
      lfsr_rst_n_d = (state_d != ST_INIT);
      misr_clr_d   = (state_d == ST_INIT);
      lfsr_en_d    = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      scan_en_d    = lfsr_en_d;
      done_d       = (state_d == ST_DONE);
      // The first pattern's shift unloads uncaptured state, so it is not compacted.
      misr_en_d    = (state_d == ST_UNLOAD) ||
                     ((state_d == ST_SHIFT) &&
                      ((state_q == ST_CAPTURE) ||
                       ((state_q == ST_SHIFT) && (pat_cnt != '0))));

      pass_d = pass_q;
      if (state_q == ST_COMPARE) begin
         pass_d = (misr_sig == GOLDEN_SIG);
      end else if (state_d == ST_INIT) begin
         pass_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         test_mode_q  <= 1'b0;
         lfsr_rst_n_q <= 1'b1;
         lfsr_en_q    <= 1'b0;
         misr_clr_q   <= 1'b0;
         misr_en_q    <= 1'b0;
         scan_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         test_mode_q  <= test_mode_d;
         lfsr_rst_n_q <= lfsr_rst_n_d;
         lfsr_en_q    <= lfsr_en_d;
         misr_clr_q   <= misr_clr_d;
         misr_en_q    <= misr_en_d;
         scan_en_q    <= scan_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign test_mode  = test_mode_q;
   assign lfsr_rst_n = lfsr_rst_n_q;
   assign lfsr_en    = lfsr_en_q;
   assign misr_clr   = misr_clr_q;
   assign misr_en    = misr_en_q;
   assign scan_en    = scan_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_lbist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lbist_ctrl : self-checking bench for lbist_ctrl (two parameter sets)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lbist_ctrl;

   localparam int C_A = 4;
   localparam int N_A = 3;
   localparam int C_B = 2;
   localparam int N_B = 1;
   localparam int SW  = 20;
   localparam logic [SW-1:0] G_A = 20'hA5C3E;
   localparam logic [SW-1:0] G_B = 20'h3B172;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic [SW-1:0] sig_a = '0;
   logic [SW-1:0] sig_b = '0;

   logic tm_a, rn_a, le_a, mc_a, me_a, se_a, busy_a, done_a, pass_a;
   logic tm_b, rn_b, le_b, mc_b, me_b, se_b, busy_b, done_b, pass_b;
   logic [7:0] obs_a, obs_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lbist_ctrl #(.CHAIN_LEN(C_A), .N_PATTERNS(N_A), .SIG_W(SW), .GOLDEN_SIG(G_A)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .misr_sig(sig_a),
      .test_mode(tm_a), .lfsr_rst_n(rn_a), .lfsr_en(le_a), .misr_clr(mc_a),
      .misr_en(me_a), .scan_en(se_a), .busy(busy_a), .done(done_a), .pass(pass_a)
   );

   lbist_ctrl #(.CHAIN_LEN(C_B), .N_PATTERNS(N_B), .SIG_W(SW), .GOLDEN_SIG(G_B)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .misr_sig(sig_b),
      .test_mode(tm_b), .lfsr_rst_n(rn_b), .lfsr_en(le_b), .misr_clr(mc_b),
      .misr_en(me_b), .scan_en(se_b), .busy(busy_b), .done(done_b), .pass(pass_b)
   );

   // {test_mode, lfsr_rst_n, lfsr_en, misr_clr, misr_en, scan_en, busy, done}
   assign obs_a = {tm_a, rn_a, le_a, mc_a, me_a, se_a, busy_a, done_a};
   assign obs_b = {tm_b, rn_b, le_b, mc_b, me_b, se_b, busy_b, done_b};

   // Expected outputs k cycles after the first INIT cycle (k < 0: idle).
   function automatic logic [7:0] model(input int k, input int c, input int n);
      int  len;
      int  p;
      int  j;
      logic m;
      len = 1 + n * (c + 1) + c + 1;
      if (k < 0) return 8'b0100_0000;
      if (k == 0) return 8'b1001_0010;
      if (k <= n * (c + 1)) begin
         p = (k - 1) / (c + 1);
         j = (k - 1) % (c + 1);
         m = (p > 0);
         if (j < c) return {4'b1110, m, 3'b110};
         return 8'b1100_0010;
      end
      if (k <= n * (c + 1) + c) return 8'b1110_1110;
      if (k == len - 1) return 8'b1100_0010;
      return 8'b0100_0001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic st, input logic [SW-1:0] sg);
      if (sel == 0) begin
         start_a = st;
         sig_a   = sg;
      end else begin
         start_b = st;
         sig_b   = sg;
      end
   endtask

   // mode 0: 1-cycle start pulse, 1: random start noise while busy, 2: start held high
   task automatic run(input int sel, input bit good, input int mode, input int tail);
      int c, n, len;
      int n_scan0, n_misr, n_lfsr, n_busy;
      logic [7:0] o;
      logic p, st;
      logic [SW-1:0] g, sg;
      c = (sel == 0) ? C_A : C_B;
      n = (sel == 0) ? N_A : N_B;
      g = (sel == 0) ? G_A : G_B;
      len = 1 + n * (c + 1) + c + 1;
      n_scan0 = 0; n_misr = 0; n_lfsr = 0; n_busy = 0;
      drive(sel, 1'b1, SW'($urandom));
      for (int k = 0; k <= len; k++) begin
         step();
         o = (sel == 0) ? obs_a : obs_b;
         p = (sel == 0) ? pass_a : pass_b;
         chk($sformatf("dut%0d_out_k%0d", sel, k), 32'(o), 32'(model(k, c, n)));
         chk($sformatf("dut%0d_pass_k%0d", sel, k), 32'(p), (k == len) ? 32'(good) : 32'd0);
         if (o[1] && !o[2]) n_scan0++;
         n_misr += int'(o[3]);
         n_lfsr += int'(o[5]);
         n_busy += int'(o[1]);
         st = (mode == 2) ? 1'b1 : (mode == 1 && k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
         sg = (k == len - 1) ? (good ? g : g ^ 1) : SW'($urandom);
         drive(sel, st, sg);
      end
      chk($sformatf("dut%0d_busy_cycles", sel), 32'(n_busy), 32'(1 + n * (c + 1) + c + 1));
      chk($sformatf("dut%0d_scan0_cycles", sel), 32'(n_scan0), 32'(n + 2));
      chk($sformatf("dut%0d_misr_cycles", sel), 32'(n_misr), 32'((n - 1) * c + c));
      chk($sformatf("dut%0d_lfsr_cycles", sel), 32'(n_lfsr), 32'(n * c + c));
      for (int t = 1; t <= tail; t++) begin
         step();
         o = (sel == 0) ? obs_a : obs_b;
         p = (sel == 0) ? pass_a : pass_b;
         if (mode == 2) begin
            chk($sformatf("dut%0d_rearm_init", sel), 32'(o), 32'(model(0, c, n)));
            chk($sformatf("dut%0d_rearm_pass", sel), 32'(p), 32'd0);
            break;
         end
         chk($sformatf("dut%0d_done_hold_t%0d", sel, t), 32'(o), 32'(model(len, c, n)));
         chk($sformatf("dut%0d_pass_hold_t%0d", sel, t), 32'(p), 32'(good));
      end
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b1;
      start_b = 1'b1;
      repeat (3) step();
      chk("reset_out_a", 32'(obs_a), 32'(model(-1, C_A, N_A)));
      chk("reset_pass_a", 32'(pass_a), 32'd0);
      chk("reset_out_b", 32'(obs_b), 32'(model(-1, C_B, N_B)));
      chk("reset_pass_b", 32'(pass_b), 32'd0);
      start_a = 1'b0;
      start_b = 1'b0;
      rst = 1'b0;
      repeat ($urandom_range(2, 5)) begin
         step();
         chk("idle_out_a", 32'(obs_a), 32'(model(-1, C_A, N_A)));
         chk("idle_out_b", 32'(obs_b), 32'(model(-1, C_B, N_B)));
      end

      run(0, 1'b1, 0, 3);
      run(0, 1'b0, 1, 2);
      run(0, 1'b1, 2, 1);
      start_a = 1'b0;

      // Continue the re-armed run into the second shift cycle of pattern 2, then reset.
      for (int k = 1; k <= 2 * (C_A + 1) + 2; k++) begin
         step();
         chk($sformatf("abort_out_k%0d", k), 32'(obs_a), 32'(model(k, C_A, N_A)));
      end
      rst = 1'b1;
      start_a = 1'b1;
      step();
      chk("abort_reset_out", 32'(obs_a), 32'(model(-1, C_A, N_A)));
      chk("abort_reset_pass", 32'(pass_a), 32'd0);
      rst = 1'b0;
      start_a = 1'b0;
      step();
      chk("abort_idle_out", 32'(obs_a), 32'(model(-1, C_A, N_A)));
      run(0, 1'b1, 0, 2);

      chk("b_idle_before_run", 32'(obs_b), 32'(model(-1, C_B, N_B)));
      run(1, 1'b1, 0, 2);
      run(1, 1'b0, 1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
